interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 No parameters; fixed at 8 request lines, IR0 highest priority.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 IR  in  8  raw interrupt request lines, synchronous to CLK.
REQ-005 IMR  in  8  mask from control logic (OCW1); 1 = masked.
REQ-006 LTIM  in  1  1 = level-triggered, 0 = edge-triggered (ICW1).
REQ-007 AEOI  in  1  1 = automatic EOI on trailing edge of second INTA.
REQ-008 EOI  in  1  one-cycle non-specific EOI strobe from OCW2 decode.
REQ-009 ICW2  in  8  vector base; bits [7:3] used.
REQ-010 INTA  in  1  CPU acknowledge, active-low, synchronised upstream.
REQ-011 INT  out  1  interrupt request to CPU, registered.
REQ-012 HIGHEST  out  8  one-hot acknowledged level fed to cascade stage; 8'b00000000 when idle.
REQ-013 VECTOR  out  8  {ICW2[7:3], level[2:0]}, valid while VECTOR_EN = 1.
REQ-014 VECTOR_EN  out  1  1 while sequencer drives the data bus (second INTA low).
REQ-015 ISR  out  8  in-service register, visible for OCW3 reads.
REQ-016 IRR  out  8  request register, visible for OCW3 reads.

Function
REQ-017 Edge mode: IRR[i] sets the cycle after IR[i] goes 0->1 (registered previous IR); clears on acknowledge of level i.
REQ-018 Level mode: IRR[i] equals IR[i] registered one cycle.
REQ-019 Candidate = lowest-index bit of IRR & ~IMR whose index is strictly below the lowest set ISR bit (any index if ISR = 0).
REQ-020 INT sets the cycle after a candidate exists: IR rise at edge N -> IRR at N+1 -> INT at N+2.
REQ-021 States: IDLE, ACK1, WAIT2, ACK2; INTA edges detected from a registered INTA copy.
REQ-022 IDLE -> ACK1 on INTA falling edge: latch candidate into HIGHEST, set ISR bit, clear edge-mode IRR bit, clear INT.
REQ-023 No candidate at the first falling edge -> spurious: HIGHEST = 8'b10000000, ISR unchanged, VECTOR level = 7.
REQ-024 ACK1 -> WAIT2 on INTA rising edge; WAIT2 -> ACK2 on next falling edge; VECTOR_EN = 1 throughout ACK2.
REQ-025 ACK2 -> IDLE on INTA rising edge: VECTOR_EN = 0, HIGHEST = 0; if AEOI, clear the ISR bit set in ACK1 (not on spurious).
REQ-026 HIGHEST is stable from the first falling edge to the second rising edge of INTA.
REQ-027 EOI clears the lowest-index set ISR bit; EOI with ISR = 0 is a no-op.
REQ-028 EOI in the same cycle as an ISR set: EOI acts on the pre-set ISR; the new bit remains set.
REQ-029 IMR change mid-sequence does not alter the latched HIGHEST; it affects only the next candidate.
REQ-030 INT re-evaluated from IDLE only; never asserted in ACK1/WAIT2/ACK2.

Reset
REQ-031 RST clears IRR, ISR, HIGHEST, VECTOR, VECTOR_EN, INT and previous-IR register; state = IDLE; registered INTA = 1.
REQ-032 RST asserted mid-sequence aborts it; the first post-reset INTA falling edge is treated as the first pulse.

Structure
REQ-033 Shared package pic_pkg holds state encoding, NUM_IR = 8 and SPURIOUS_LEVEL = 3'd7.
REQ-034 One sub-module, priority_resolver: combinational lowest-index one-hot pick of a masked 8-bit vector against ISR.

Verification
REQ-035 Edge mode, IR3 pulse, IMR = 0, ICW2 = 8'h40 -> INT two cycles later; two INTA pulses -> HIGHEST = 8'h08, VECTOR = 8'h43, ISR = 8'h08.
REQ-036 IR5 and IR2 rise together -> IR2 served first (VECTOR low bits 2); after EOI, IR5 served.
REQ-037 ISR = 8'h04 pending, IR6 rises -> INT stays 0; IR0 rises -> INT = 1.
REQ-038 Level mode, IR4 dropped before first INTA -> HIGHEST = 8'h80, VECTOR = {ICW2[7:3],3'd7}, ISR unchanged.
REQ-039 AEOI = 1, IR1 acknowledged -> ISR = 0 the cycle after the second INTA rising edge.
REQ-040 RST during WAIT2 -> all outputs 0, state IDLE; next IR7 request acknowledged normally.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8-level interrupt sequencer.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;

  localparam logic [LVL_W-1:0]  SPURIOUS_LEVEL  = 3'd7;
  localparam logic [NUM_IR-1:0] SPURIOUS_ONEHOT = 8'b1000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } state_e;

  // Vector byte driven during the second acknowledge.
  typedef struct packed {
    logic [4:0]       base;
    logic [LVL_W-1:0] level;
  } vector_t;

  // Isolate the lowest set bit (highest priority in-service level).
  function automatic logic [NUM_IR-1:0] lowest_one(input logic [NUM_IR-1:0] v);
    return v & ((~v) + NUM_IR'(1));
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request/acknowledge/status bundle between control logic, CPU side and sequencer.
interface interrupt_sequencer_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0] IR;
  logic [NUM_IR-1:0] IMR;
  logic              LTIM;
  logic              AEOI;
  logic              EOI;
  logic [7:0]        ICW2;
  logic              INTA;

  logic              INT;
  logic [NUM_IR-1:0] HIGHEST;
  logic [7:0]        VECTOR;
  logic              VECTOR_EN;
  logic [NUM_IR-1:0] ISR;
  logic [NUM_IR-1:0] IRR;

  modport master (
    output IR, IMR, LTIM, AEOI, EOI, ICW2, INTA,
    input  INT, HIGHEST, VECTOR, VECTOR_EN, ISR, IRR
  );

  modport slave (
    input  IR, IMR, LTIM, AEOI, EOI, ICW2, INTA,
    output INT, HIGHEST, VECTOR, VECTOR_EN, ISR, IRR
  );

endinterface

// File: rtl/priority_resolver.sv
// Combinational pick of the highest-priority unmasked request that can
// preempt everything currently in service.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req_i,
  input  logic [NUM_IR-1:0] mask_i,
  input  logic [NUM_IR-1:0] isr_i,
  output logic [NUM_IR-1:0] grant_c_o,
  output logic [LVL_W-1:0]  level_c_o,
  output logic              valid_c_o
);

  logic blocked;

  // Scan from IR0 upward; an in-service bit blocks itself and all lower priorities.
  always_comb begin
    grant_c_o = '0;
    level_c_o = '0;
    valid_c_o = 1'b0;
    blocked   = 1'b0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (isr_i[i]) begin
        blocked = 1'b1;
      end
      if (!blocked && !valid_c_o && req_i[i] && !mask_i[i]) begin
        grant_c_o[i] = 1'b1;
        level_c_o    = LVL_W'(i);
        valid_c_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 8-level interrupt sequencer: request capture, priority resolution and the
// two-pulse INTA acknowledge cycle that places the vector on the bus.
module interrupt_sequencer
  import pic_pkg::*;
(
  input logic                  CLK,
  input logic                  RST,
  interrupt_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [NUM_IR-1:0] ir_prev_q;
  logic              inta_q;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] highest_q, highest_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              spurious_q, spurious_d;
  vector_t           vector_q, vector_d;
  logic              vector_en_q, vector_en_d;
  logic              int_q, int_d;

  logic [NUM_IR-1:0] cand_grant;
  logic [LVL_W-1:0]  cand_level;
  logic              cand_valid;

  logic              inta_fall;
  logic              inta_rise;
  logic [NUM_IR-1:0] isr_set;
  logic [NUM_IR-1:0] isr_eoi_clr;
  logic [NUM_IR-1:0] isr_aeoi_clr;
  logic [NUM_IR-1:0] irr_ack_clr;
  logic              unused_icw2;

  assign unused_icw2 = ^bus.ICW2[2:0];

  priority_resolver u_resolver (
    .req_i     (irr_q),
    .mask_i    (bus.IMR),
    .isr_i     (isr_q),
    .grant_c_o (cand_grant),
    .level_c_o (cand_level),
    .valid_c_o (cand_valid)
  );

  assign inta_fall = inta_q & ~bus.INTA;
  assign inta_rise = ~inta_q & bus.INTA;

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    highest_d    = highest_q;
    level_d      = level_q;
    spurious_d   = spurious_q;
    vector_d     = vector_q;
    vector_en_d  = vector_en_q;
    int_d        = 1'b0;
    isr_set      = '0;
    isr_aeoi_clr = '0;
    irr_ack_clr  = '0;
    isr_eoi_clr  = bus.EOI ? lowest_one(isr_q) : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (inta_fall) begin
          state_d = ST_ACK1;
          if (cand_valid) begin
            highest_d   = cand_grant;
            level_d     = cand_level;
            spurious_d  = 1'b0;
            isr_set     = cand_grant;
            irr_ack_clr = cand_grant;
          end else begin
            highest_d  = SPURIOUS_ONEHOT;
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end else begin
          int_d = cand_valid;
        end
      end
      ST_ACK1: begin
        if (inta_rise) begin
          state_d = ST_WAIT2;
        end
      end
      ST_WAIT2: begin
        if (inta_fall) begin
          state_d     = ST_ACK2;
          vector_en_d = 1'b1;
          vector_d    = '{base: bus.ICW2[7:3], level: level_q};
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          state_d     = ST_IDLE;
          vector_en_d = 1'b0;
          vector_d    = '0;
          highest_d   = '0;
          if (bus.AEOI && !spurious_q) begin
            isr_aeoi_clr = highest_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // EOI acts on the pre-update ISR, so a bit set this cycle survives.
    isr_d = (isr_q & ~isr_eoi_clr & ~isr_aeoi_clr) | isr_set;

    if (bus.LTIM) begin
      irr_d = bus.IR;
    end else begin
      irr_d = (irr_q & ~irr_ack_clr) | (bus.IR & ~ir_prev_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ir_prev_q   <= '0;
      inta_q      <= 1'b1;
      irr_q       <= '0;
      isr_q       <= '0;
      highest_q   <= '0;
      level_q     <= '0;
      spurious_q  <= 1'b0;
      vector_q    <= '0;
      vector_en_q <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_prev_q   <= bus.IR;
      inta_q      <= bus.INTA;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      highest_q   <= highest_d;
      level_q     <= level_d;
      spurious_q  <= spurious_d;
      vector_q    <= vector_d;
      vector_en_q <= vector_en_d;
      int_q       <= int_d;
    end
  end

  assign bus.INT       = int_q;
  assign bus.HIGHEST   = highest_q;
  assign bus.VECTOR    = vector_q;
  assign bus.VECTOR_EN = vector_en_q;
  assign bus.ISR       = isr_q;
  assign bus.IRR       = irr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed scoreboard bench for interrupt_sequencer: stimulus queues expected
// acknowledge results, a monitor checks them when VECTOR_EN rises.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] vec;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  exp_t exp_q[$];
  logic ven_prev = 1'b0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic eoi_pulse();
    bus.EOI = 1'b1;
    tick(1);
    bus.EOI = 1'b0;
  endtask

  // Full two-pulse acknowledge; optional EOI on the first falling edge and an
  // IMR value applied between the pulses.
  task automatic ack(input logic [7:0] exp_hi, input logic [7:0] exp_vec,
                     input logic eoi_fall, input logic [7:0] imr_mid,
                     output logic [7:0] isr_ack2, output logic [7:0] isr_after);
    exp_q.push_back('{hi: exp_hi, vec: exp_vec});
    bus.INTA = 1'b0;
    bus.EOI  = eoi_fall;
    tick(1);
    bus.EOI  = 1'b0;
    chk("highest_ack1", bus.HIGHEST, exp_hi);
    chk("int_ack1", 8'(bus.INT), 8'd0);
    bus.IMR = imr_mid;
    tick(1);
    bus.INTA = 1'b1;
    tick(2);
    bus.INTA = 1'b0;
    tick(2);
    chk("highest_ack2", bus.HIGHEST, exp_hi);
    chk("int_ack2", 8'(bus.INT), 8'd0);
    isr_ack2 = bus.ISR;
    bus.INTA = 1'b1;
    tick(1);
    chk("highest_idle", bus.HIGHEST, 8'h00);
    chk("vector_en_idle", 8'(bus.VECTOR_EN), 8'd0);
    isr_after = bus.ISR;
    tick(1);
  endtask

  // Scoreboard monitor: compare on each VECTOR_EN rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ven_prev = 1'b0;
      end else begin
        if (bus.VECTOR_EN && !ven_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_vector", bus.VECTOR, 8'hxx);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_highest", bus.HIGHEST, e.hi);
            chk("sb_vector", bus.VECTOR, e.vec);
          end
        end
        ven_prev = bus.VECTOR_EN;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s2;
    logic [7:0] sa;
    rst      = 1'b1;
    bus.IR   = '0;
    bus.IMR  = '0;
    bus.LTIM = 1'b0;
    bus.AEOI = 1'b0;
    bus.EOI  = 1'b0;
    bus.ICW2 = 8'h40;
    bus.INTA = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_int", 8'(bus.INT), 8'd0);
    chk("rst_highest", bus.HIGHEST, 8'h00);
    chk("rst_vector", bus.VECTOR, 8'h00);
    chk("rst_vector_en", 8'(bus.VECTOR_EN), 8'd0);
    chk("rst_isr", bus.ISR, 8'h00);
    chk("rst_irr", bus.IRR, 8'h00);
    tick(1);

    // IR3 edge: IRR one cycle later, INT two cycles later, vector 43.
    bus.IR = 8'h08;
    tick(1);
    chk("t1_irr", bus.IRR, 8'h08);
    chk("t1_int_early", 8'(bus.INT), 8'd0);
    tick(1);
    chk("t1_int", 8'(bus.INT), 8'd1);
    ack(8'h08, 8'h43, 1'b0, 8'h00, s2, sa);
    chk("t1_isr_ack2", s2, 8'h08);
    chk("t1_isr_after", sa, 8'h08);
    chk("t1_irr_clr", bus.IRR, 8'h00);
    bus.IR = 8'h00;
    eoi_pulse();
    chk("t1_eoi", bus.ISR, 8'h00);
    eoi_pulse();
    chk("t1_eoi_noop", bus.ISR, 8'h00);

    // IR5 and IR2 together: IR2 first; IR6 blocked by ISR2, IR0 preempts.
    bus.IR = 8'h24;
    tick(2);
    chk("t2_int", 8'(bus.INT), 8'd1);
    ack(8'h04, 8'h42, 1'b0, 8'h00, s2, sa);
    chk("t2_isr", sa, 8'h04);
    chk("t2_irr", bus.IRR, 8'h20);
    chk("t2_int_blocked5", 8'(bus.INT), 8'd0);
    bus.IR = 8'h64;
    tick(3);
    chk("t2_irr6", bus.IRR, 8'h60);
    chk("t2_int_blocked6", 8'(bus.INT), 8'd0);
    bus.IR = 8'h65;
    tick(2);
    chk("t2_int_ir0", 8'(bus.INT), 8'd1);
    ack(8'h01, 8'h40, 1'b0, 8'h00, s2, sa);
    chk("t2_isr_nested", sa, 8'h05);
    eoi_pulse();
    chk("t2_eoi_lowest", bus.ISR, 8'h04);
    eoi_pulse();
    chk("t2_eoi_all", bus.ISR, 8'h00);
    tick(1);
    chk("t2_int_ir5", 8'(bus.INT), 8'd1);
    ack(8'h20, 8'h45, 1'b0, 8'h00, s2, sa);
    chk("t2_isr5", sa, 8'h20);

    // EOI coincident with the ISR set, and IMR change between the pulses.
    bus.IR = 8'h67;
    tick(2);
    chk("t3_int_ir1", 8'(bus.INT), 8'd1);
    ack(8'h02, 8'h41, 1'b1, 8'hFF, s2, sa);
    chk("t3_isr_eoi_set", s2, 8'h02);
    bus.IMR = 8'h00;
    tick(1);
    chk("t3_int_blocked6", 8'(bus.INT), 8'd0);
    eoi_pulse();
    chk("t3_eoi", bus.ISR, 8'h00);
    tick(1);
    chk("t3_int_ir6", 8'(bus.INT), 8'd1);
    ack(8'h40, 8'h46, 1'b0, 8'h00, s2, sa);
    eoi_pulse();
    bus.IR = 8'h00;
    tick(2);
    chk("t3_idle_int", 8'(bus.INT), 8'd0);

    // Masked request latches in IRR but raises INT only once unmasked.
    bus.IMR = 8'h08;
    bus.IR  = 8'h08;
    tick(3);
    chk("t4_irr_masked", bus.IRR, 8'h08);
    chk("t4_int_masked", 8'(bus.INT), 8'd0);
    bus.IMR = 8'h00;
    tick(1);
    chk("t4_int_unmasked", 8'(bus.INT), 8'd1);
    ack(8'h08, 8'h43, 1'b0, 8'h00, s2, sa);
    eoi_pulse();
    bus.IR = 8'h00;
    tick(1);

    // Level mode: IR4 withdrawn before INTA gives a spurious level-7 cycle.
    bus.LTIM = 1'b1;
    bus.IR   = 8'h10;
    tick(1);
    chk("t5_irr_level", bus.IRR, 8'h10);
    tick(1);
    chk("t5_int", 8'(bus.INT), 8'd1);
    bus.IR = 8'h00;
    tick(2);
    chk("t5_int_drop", 8'(bus.INT), 8'd0);
    ack(8'h80, 8'h47, 1'b0, 8'h00, s2, sa);
    chk("t5_isr_spurious", s2, 8'h00);
    chk("t5_isr_after", sa, 8'h00);
    bus.LTIM = 1'b0;
    tick(1);

    // Automatic EOI clears the IR1 in-service bit after the second rising edge.
    bus.AEOI = 1'b1;
    bus.IR   = 8'h02;
    tick(2);
    chk("t6_int", 8'(bus.INT), 8'd1);
    ack(8'h02, 8'h41, 1'b0, 8'h00, s2, sa);
    chk("t6_isr_ack2", s2, 8'h02);
    chk("t6_isr_aeoi", sa, 8'h00);
    bus.AEOI = 1'b0;
    bus.IR   = 8'h00;
    tick(1);

    // Reset in WAIT2 aborts the sequence; IR7 then serviced normally.
    bus.IR = 8'h80;
    tick(2);
    chk("t7_int", 8'(bus.INT), 8'd1);
    bus.INTA = 1'b0;
    tick(2);
    bus.INTA = 1'b1;
    tick(2);
    chk("t7_highest_wait2", bus.HIGHEST, 8'h80);
    chk("t7_isr_wait2", bus.ISR, 8'h80);
    rst    = 1'b1;
    bus.IR = 8'h00;
    tick(1);
    rst = 1'b0;
    chk("t7_rst_int", 8'(bus.INT), 8'd0);
    chk("t7_rst_highest", bus.HIGHEST, 8'h00);
    chk("t7_rst_vector_en", 8'(bus.VECTOR_EN), 8'd0);
    chk("t7_rst_isr", bus.ISR, 8'h00);
    chk("t7_rst_irr", bus.IRR, 8'h00);
    bus.ICW2 = 8'hAD;
    bus.IR   = 8'h80;
    tick(1);
    chk("t7_irr", bus.IRR, 8'h80);
    tick(1);
    chk("t7_int_again", 8'(bus.INT), 8'd1);
    ack(8'h80, 8'hAF, 1'b0, 8'h00, s2, sa);
    chk("t7_isr", sa, 8'h80);
    eoi_pulse();
    chk("t7_eoi", bus.ISR, 8'h00);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      tick(1);
    end
    chk("sb_drain", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
